// File: rtl/llc_output_encoder.sv
// LLC transmit-side encoder: routes one pipeline message per cycle into one of
// four per-channel FIFOs, each draining independently with valid/ready.
module llc_output_encoder #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4,
   parameter int USE_W  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  msg_valid,
   input  logic [1:0]            msg_chan,
   input  logic [DATA_W-1:0]     msg_data,
   output logic                  msg_ready,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic [4*DATA_W-1:0]   out_data,
   output logic [3:0]            full_mask,
   output logic [4*USE_W-1:0]    usage,
   output logic                  idle
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Ready looks only at registered full flags, so a pop never frees space for a same-cycle push.
   assign msg_ready = !full_mask[msg_chan];
   assign idle      = !(|out_valid) && !msg_valid;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_queue
         logic [PTR_W-1:0]  r_wr_ptr;
         logic [PTR_W-1:0]  r_rd_ptr;
         logic [USE_W-1:0]  r_usage;
         logic [DATA_W-1:0] r_mem [DEPTH];
         logic              w_push;
         logic              w_pop;

         assign w_push = msg_valid && msg_ready && (msg_chan == 2'(gi)) && !flush;
         assign w_pop  = out_valid[gi] && out_ready[gi] && !flush;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_usage  <= '0;
            end else if (flush) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_usage  <= '0;
            end else begin
               if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
               if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
               case ({w_push, w_pop})
                  2'b10:   r_usage <= r_usage + USE_W'(1);
                  2'b01:   r_usage <= r_usage - USE_W'(1);
                  default: r_usage <= r_usage;
               endcase
            end
         end

         // Payload storage carries no reset; its contents matter only while usage is nonzero.
         always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr] <= msg_data;
         end

         assign out_valid[gi]                  = (r_usage != '0);
         assign full_mask[gi]                  = (r_usage == USE_W'(DEPTH));
         assign out_data[gi*DATA_W +: DATA_W]  = r_mem[r_rd_ptr];
         assign usage[gi*USE_W +: USE_W]       = r_usage;
      end
   endgenerate

endmodule

// File: doc/llc_output_encoder.md
Name: llc_output_encoder

Overview:
- Transmit-side counterpart of the LLC input decoder. The decoder selects one incoming message per cycle by priority. This block takes one outgoing message per cycle from the LLC pipeline and routes it by channel code into one of four per-channel queues: rsp_out, fwd_out, mem_req, dma_rsp_out.
- Each queue drains independently onto its output channel with a valid/ready handshake.
- Per-queue full flags go back to the decoder and pipeline so they can stall issue.

Parameters:
- DATA_W, 64, width of one message payload.
- DEPTH, 4, entries per channel queue; power of two, >= 2.
- USE_W, 3, usage counter width; equals clog2(DEPTH+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all queues
- msg_valid  in  1  pipeline offers a message
- msg_chan  in  2  target channel: 0 rsp_out, 1 fwd_out, 2 mem_req, 3 dma_rsp_out
- msg_data  in  DATA_W  message payload
- msg_ready  out  1  target queue (selected by msg_chan) not full
- out_valid  out  4  per-channel head valid; bit i is channel i
- out_ready  in  4  per-channel downstream ready
- out_data  out  4*DATA_W  per-channel head payload; slice i is [i*DATA_W +: DATA_W]
- full_mask  out  4  per-queue full flag
- usage  out  4*USE_W  per-queue occupancy
- idle  out  1  all queues empty and msg_valid low

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-low.
  - While rst=0, all read/write pointers and usage counters are 0. This gives out_valid=0, full_mask=0, usage=0, msg_ready=1, idle=1 (when msg_valid=0).
  - Payload storage is not reset; out_data is don't-care while out_valid=0.
- Handshake rules:
  - msg_ready = !full[msg_chan]. It is combinational on msg_chan and independent of msg_valid.
  - Push for queue i occurs when msg_valid & msg_ready & msg_chan==i & !flush.
  - Pop for queue i occurs when out_valid[i] & out_ready[i] & !flush.
  - out_valid[i] = (usage_i != 0). out_data slice i = storage_i[rd_ptr_i].
- Latency and ordering:
  - A message pushed at edge N is visible on out_valid and out_data after edge N; it can be popped at edge N+1.
  - There is no same-cycle bypass from input to output.
  - Each queue is strict FIFO. No ordering is enforced across channels.
- Queue update per cycle:
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Push only: wr_ptr+1, usage+1.
  - Pop only: rd_ptr+1, usage-1.
  - Push and pop together: both pointers advance, usage unchanged.
  - Usage range is 0..DEPTH. full = (usage==DEPTH); empty = (usage==0).
- Boundary conditions:
  - Full with a pop in the same cycle: msg_ready stays 0 (it depends only on the registered full flag). The push is not accepted; the pop proceeds. full_mask drops on the next cycle.
  - Empty with a push in the same cycle: usage goes 0 to 1. There is no pop, since out_valid was 0.
  - msg_valid=1 with msg_ready=0: nothing is written. The pipeline must hold msg_chan and msg_data stable until accepted.
  - out_valid[i] stays high and out_data slice i stays stable until popped. Downstream may hold out_ready low indefinitely.
  - flush=1: all pointers and usage return to 0 at the next edge. flush overrides simultaneous push and pop. msg_ready is still computed normally, but the message is discarded.
  - Reset mid-operation: all queued messages are lost immediately (asynchronous); outputs return to reset values.
- idle = (all usage==0) & !msg_valid. It is combinational.
- There are no internal state machines beyond the per-queue pointer/counter pairs. Four independent queues plus the routing logic total roughly 150-250 lines.

Test Plan:
- Reset: rst low, then high -> out_valid=4'b0000, full_mask=0, usage all 0, idle=1, msg_ready=1.
- Single message: push chan=2, data=0xAB at edge 1 -> out_valid=4'b0100 and mem_req data 0xAB after edge 1; out_ready[2]=1 -> out_valid[2]=0 after edge 2, usage_2 back to 0.
- Fill and back-pressure (DEPTH=4): out_ready=0, push 0x1..0x5 to chan 0 -> first four accepted, usage_0=4, full_mask[0]=1, msg_ready=0 on the fifth; drain -> outputs 0x1,0x2,0x3,0x4 in order, 0x5 is held by the pipeline and then accepted.
- Full with simultaneous pop: queue 1 full, out_ready[1]=1 and push to chan 1 in the same cycle -> push rejected, usage_1=3 next cycle, msg_ready=1.
- Wrap-around: 10 push/pop pairs on chan 3 at steady usage 1 -> payloads exit in order across pointer wrap; usage stays 1.
- Flush: queues holding 2/1/3/0 entries, flush=1 while pushing chan 0 -> all usage 0, out_valid=0, pushed message discarded.
